// File: rtl/streamer_pkg.sv
// streamer_pkg: shared types and constants for the BRAM-to-UART word streamer.
package streamer_pkg;
   localparam int BYTE_WIDTH = 8;
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_HOLD,
      S_DRAIN,
      S_DONE
   } streamer_state_t;
endpackage

// File: rtl/bram_uart_streamer.sv
// bram_uart_streamer: reads a run of BRAM words and feeds them MSB-byte-first
// into a trigger/busy byte transmitter.
module bram_uart_streamer
   import streamer_pkg::*;
#(
   parameter int ADDR_WIDTH   = 15,
   parameter int WORD_BYTES   = 4,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start_in,
   input  logic                  abort_in,
   input  logic [ADDR_WIDTH-1:0] base_addr_in,
   input  logic [ADDR_WIDTH:0]   word_count_in,
   output logic [ADDR_WIDTH-1:0] addr_out,
   input  logic [WORD_BYTES*8-1:0] rd_data_in,
   output logic [7:0]            byte_out,
   output logic                  trigger_out,
   input  logic                  busy_in,
   output logic                  busy_out,
   output logic                  done_out,
   output logic [ADDR_WIDTH:0]   words_sent_out
);
   localparam int WW = WORD_BYTES * BYTE_WIDTH;
   localparam int CW = ADDR_WIDTH + 1;
   localparam int BW = $clog2(WORD_BYTES) + 1;
   localparam int LW = $clog2(READ_LATENCY + 1) + 1;

   streamer_state_t state_q, state_d;
   logic [LW-1:0]         lat_q, lat_d;
   logic [BW-1:0]         bcnt_q, bcnt_d;
   logic [CW-1:0]         idx_q, idx_d, cnt_q, cnt_d, ws_q, ws_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
   logic [WW-1:0]         shift_q, shift_d;
   logic                  trig_q, trig_d, busy_q, busy_d, done_q, done_d;
   logic                  lat_done, last_byte, last_word, word_end;

   assign lat_done  = lat_q == LW'(READ_LATENCY);
   assign last_byte = bcnt_q == BW'(WORD_BYTES);
   assign last_word = idx_q + CW'(1) == cnt_q;
   assign word_end  = state_q == S_DRAIN && !busy_in && last_byte && !abort_in;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_in) state_d = word_count_in == '0 ? S_DONE : S_FETCH;
         S_FETCH: if (lat_done) state_d = S_SEND;
         S_SEND:  if (!busy_in) state_d = S_HOLD;
         S_HOLD:  state_d = S_DRAIN;
         S_DRAIN: if (!busy_in) state_d = !last_byte ? S_SEND : (last_word ? S_DONE : S_FETCH);
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort_in && state_q != S_IDLE) state_d = S_IDLE;
   end

   always_comb begin
      lat_d   = lat_q;
      bcnt_d  = bcnt_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ws_d    = ws_q;
      base_d  = base_q;
      addr_d  = addr_q;
      shift_d = shift_q;
      trig_d  = 1'b0;
      case (state_q)
         S_IDLE: if (start_in && word_count_in != '0) begin
            base_d = base_addr_in;
            addr_d = base_addr_in;
            cnt_d  = word_count_in;
            idx_d  = '0;
            ws_d   = '0;
            lat_d  = '0;
         end
         S_FETCH: begin
            lat_d = lat_q + LW'(1);
            if (lat_done) begin
               shift_d = rd_data_in;
               bcnt_d  = '0;
            end
         end
         S_SEND: trig_d = !busy_in;
         S_HOLD: begin
            shift_d = shift_q << BYTE_WIDTH;
            bcnt_d  = bcnt_q + BW'(1);
         end
         default: ;
      endcase
      // word boundary: count the finished word and, if more remain, point at the next one
      if (word_end) begin
         ws_d = ws_q + CW'(1);
         if (!last_word) begin
            idx_d  = idx_q + CW'(1);
            addr_d = base_q + idx_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
            lat_d  = '0;
         end
      end
      busy_d = state_d != S_IDLE;
      done_d = state_d == S_DONE;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         lat_q   <= '0;
         bcnt_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         ws_q    <= '0;
         base_q  <= '0;
         addr_q  <= '0;
         shift_q <= '0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         lat_q   <= lat_d;
         bcnt_q  <= bcnt_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ws_q    <= ws_d;
         base_q  <= base_d;
         addr_q  <= addr_d;
         shift_q <= shift_d;
         trig_q  <= trig_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign addr_out       = addr_q;
   assign byte_out       = shift_q[WW-1 -: BYTE_WIDTH];
   assign trigger_out    = trig_q;
   assign busy_out       = busy_q;
   assign done_out       = done_q;
   assign words_sent_out = ws_q;
endmodule
